// File: rtl/cnn_result_writer.sv
// Multi-channel CNN result write-back: packs 8/16/32-bit results into words, buffers them in
// per-channel FIFOs and writes them round-robin over the lacc data port. Define
// CNN_WB_SATURATE_EN to saturate 8/16-bit elements instead of truncating them.
module cnn_result_writer #(
    parameter int unsigned CH_NUM   = 4,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned STRIDE_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    input  logic [$clog2(CH_NUM)-1:0] cfg_ch,
    input  logic [31:0]               cfg_addr,
    input  logic [STRIDE_W-1:0]       cfg_stride,
    input  logic [1:0]                cfg_elem_size,
    input  logic                      start,
    input  logic [CH_NUM-1:0]         ch_en_i,
    input  logic                      flush,
    input  logic [CH_NUM-1:0]         res_valid,
    input  logic [CH_NUM*32-1:0]      res_data,
    output logic                      res_stall,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    output logic [3:0]                mem_wstrb,
    output logic [1:0]                mem_size,
    output logic                      busy,
    output logic                      done
);
    localparam int unsigned ChW  = $clog2(CH_NUM);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] PtrOne = 1;

    typedef enum logic [1:0] {StIdle, StRun, StPack, StDrain} state_e;

    state_e            state_q;
    logic [1:0]        elem_size_q;
    logic [1:0]        size;
    logic [CH_NUM-1:0] en_q;
    logic [ChW-1:0]    rr_q, grant_q, grant, sel, idx;
    logic              lock_q, done_q, found, handshake;
    logic              st_idle, st_run, st_pack;

    logic [CH_NUM-1:0] full, empty, accept, pend, avail, pop;
    logic [35:0]       head   [CH_NUM];
    logic [31:0]       addr_w [CH_NUM];

`ifdef CNN_WB_SATURATE_EN
    function automatic logic [7:0] sat8(input logic signed [31:0] v);
        if (v > 32'sd127) return 8'h7f;
        if (v < -32'sd128) return 8'h80;
        return v[7:0];
    endfunction

    function automatic logic [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767) return 16'h7fff;
        if (v < -32'sd32768) return 16'h8000;
        return v[15:0];
    endfunction
`endif

    assign size      = (elem_size_q == 2'd3) ? 2'd2 : elem_size_q;
    assign st_idle   = (state_q == StIdle);
    assign st_run    = (state_q == StRun);
    assign st_pack   = (state_q == StPack);
    assign res_stall = |(full & en_q);
    assign avail     = ~empty & en_q;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        logic [31:0]         res;
        logic [7:0]          e8;
        logic [15:0]         e16;
        logic [31:0]         pk_data_q, pk_data_d, push_word;
        logic [1:0]          pk_cnt_q, pk_cnt_d;
        logic [3:0]          push_strb;
        logic                push;
        logic [PtrW:0]       wr_q, rd_q;
        logic [35:0]         mem_q [DEPTH];
        logic [31:0]         addr_q, base_q;
        logic [STRIDE_W-1:0] stride_q;

        assign res = res_data[g*32 +: 32];
`ifdef CNN_WB_SATURATE_EN
        assign e8  = sat8(res);
        assign e16 = sat16(res);
`else
        assign e8  = res[7:0];
        assign e16 = res[15:0];
`endif

        // Direction bit (MSB) distinguishes full from empty when the indices match.
        assign full[g]   = (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]) && (wr_q[PtrW] != rd_q[PtrW]);
        assign empty[g]  = (wr_q == rd_q);
        assign accept[g] = st_run & res_valid[g] & en_q[g] & ~res_stall;
        assign pend[g]   = en_q[g] & (pk_cnt_q != 2'd0);
        assign pop[g]    = handshake & (grant == ChW'(g));
        assign head[g]   = mem_q[rd_q[PtrW-1:0]];
        assign addr_w[g] = addr_q;

        always_comb begin
            pk_data_d = pk_data_q;
            pk_cnt_d  = pk_cnt_q;
            push_word = 32'h0;
            push_strb = 4'hf;
            push      = 1'b0;
            if (accept[g]) begin
                case (size)
                    2'd0: begin
                        pk_data_d = pk_data_q | (32'(e8) << {pk_cnt_q, 3'b000});
                        pk_cnt_d  = pk_cnt_q + 2'd1;
                        if (pk_cnt_q == 2'd3) begin
                            push      = 1'b1;
                            push_word = pk_data_d;
                            pk_data_d = '0;
                            pk_cnt_d  = '0;
                        end
                    end
                    2'd1: begin
                        pk_data_d = pk_data_q | (32'(e16) << {pk_cnt_q[0], 4'b0000});
                        pk_cnt_d  = pk_cnt_q + 2'd1;
                        if (pk_cnt_q[0]) begin
                            push      = 1'b1;
                            push_word = pk_data_d;
                            pk_data_d = '0;
                            pk_cnt_d  = '0;
                        end
                    end
                    default: begin
                        push      = 1'b1;
                        push_word = res;
                    end
                endcase
            end else if (st_pack && pend[g] && !full[g]) begin
                // Partial word: unfilled bytes are already zero in the packer.
                push      = 1'b1;
                push_word = pk_data_q;
                push_strb = (size == 2'd1) ? 4'b0011 : ((4'b0001 << pk_cnt_q) - 4'b0001);
                pk_data_d = '0;
                pk_cnt_d  = '0;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pk_data_q <= '0;
                pk_cnt_q  <= '0;
                wr_q      <= '0;
                rd_q      <= '0;
                addr_q    <= '0;
                base_q    <= '0;
                stride_q  <= '0;
            end else begin
                if (st_idle && cfg_valid && cfg_ch == ChW'(g)) begin
                    base_q   <= cfg_addr;
                    stride_q <= cfg_stride;
                end
                if (st_idle && start) begin
                    pk_data_q <= '0;
                    pk_cnt_q  <= '0;
                    wr_q      <= '0;
                    rd_q      <= '0;
                    addr_q    <= base_q;
                end else begin
                    pk_data_q <= pk_data_d;
                    pk_cnt_q  <= pk_cnt_d;
                    if (push) wr_q <= wr_q + PtrOne;
                    if (pop[g]) begin
                        rd_q   <= rd_q + PtrOne;
                        addr_q <= addr_q + 32'(stride_q);
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (push) mem_q[wr_q[PtrW-1:0]] <= {push_strb, push_word};
        end
    end

    // Round-robin search over non-empty enabled channels starting at rr_q.
    always_comb begin
        sel   = rr_q;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < CH_NUM; k++) begin
            idx = rr_q + ChW'(k);
            if (!found && avail[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    // A stalled request keeps its grant so address and data stay stable.
    assign grant     = lock_q ? grant_q : sel;
    assign mem_valid = lock_q | found;
    assign handshake = mem_valid & mem_ready;
    assign mem_addr  = mem_valid ? addr_w[grant] : 32'h0;
    assign mem_wdata = mem_valid ? head[grant][31:0] : 32'h0;
    assign mem_wstrb = mem_valid ? head[grant][35:32] : 4'h0;
    assign mem_size  = 2'b10;
    assign busy      = !st_idle;
    assign done      = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            elem_size_q <= '0;
            en_q        <= '0;
            rr_q        <= '0;
            grant_q     <= '0;
            lock_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            lock_q  <= mem_valid & ~mem_ready;
            grant_q <= grant;
            if (handshake) rr_q <= grant + ChW'(1);
            unique case (state_q)
                StIdle: begin
                    if (cfg_valid) elem_size_q <= cfg_elem_size;
                    if (start) begin
                        state_q <= StRun;
                        en_q    <= ch_en_i;
                        rr_q    <= '0;
                    end
                end
                StRun: begin
                    if (flush) state_q <= StPack;
                end
                StPack: begin
                    if (!(|(pend & full))) state_q <= StDrain;
                end
                StDrain: begin
                    if (!(|avail) && !mem_valid) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
